// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
//   Shared definitions for the adder-tree feeder slice: default vector
//   geometry, the feeder FSM state type and a width helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package adder_tree_pkg;

  localparam int NUM      = 18;  // operands per vector
  localparam int LEN      = 16;  // operand width, signed
  localparam int TREE_LAT = 5;   // tree latency in edges, also sum growth bits

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit so that
  // degenerate sizes still give a legal vector.
  function automatic int clog2(input int value);
    int r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_feeder_if.sv
// -----------------------------------------------------------------------------
// adder_tree_feeder_if
//   Operand input stream and result output stream of the adder-tree feeder.
//   Signals:
//     s_valid / s_ready / s_data   operand handshake (LEN-bit signed)
//     s_last                       short-vector end (ADDER_FEEDER_LAST_EN only)
//     m_valid / m_ready / m_data   result handshake (SUM_W-bit signed)
//   Modports: slave = feeder side, master = producer/consumer side.
//   Macro: ADDER_FEEDER_LAST_EN adds s_last.
// -----------------------------------------------------------------------------
interface adder_tree_feeder_if #(
  parameter int LEN   = adder_tree_pkg::LEN,
  parameter int SUM_W = adder_tree_pkg::LEN + adder_tree_pkg::TREE_LAT
);

  logic             s_valid;
  logic             s_ready;
  logic [LEN-1:0]   s_data;
`ifdef ADDER_FEEDER_LAST_EN
  logic             s_last;
`endif
  logic             m_valid;
  logic             m_ready;
  logic [SUM_W-1:0] m_data;

`ifdef ADDER_FEEDER_LAST_EN
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data);
`else
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_data);
`endif

endinterface

// File: rtl/adder_tree_feeder_sum_fifo.sv
// -----------------------------------------------------------------------------
// sum_fifo
//   Synchronous result FIFO with a registered head. No bypass: a push into an
//   empty FIFO becomes visible on the following cycle.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     push, push_data   write strobe and data (caller guarantees not full)
//     ready             consumer ready; pop = valid && ready
//     valid, data       non-empty flag and head entry
// -----------------------------------------------------------------------------
module sum_fifo
  import adder_tree_pkg::*;
#(
  parameter int SUM_W      = 21,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [SUM_W-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [SUM_W-1:0] data
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = clog2(FIFO_DEPTH + 1);

  logic [SUM_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic [SUM_W-1:0] head_q;
  logic             pop;

  assign valid = (count_q != '0);
  assign data  = head_q;
  assign pop   = valid && ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately left out of reset; only pointers, count and
  // the head register are cleared, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);

      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;

      // Head follows the oldest entry. With one entry left and a pop, the next
      // oldest is the value being pushed right now (not yet in the array).
      if (pop && count_q > CNT_W'(1))
        head_q <= mem[ptr_inc(rd_q)];
      else if (push && (count_q == '0 || (pop && count_q == CNT_W'(1))))
        head_q <= push_data;
    end
  end

endmodule

// File: rtl/adder_tree_feeder.sv
// -----------------------------------------------------------------------------
// adder_tree_feeder
//   Packs NUM signed LEN-bit operands into tree_in for a pipelined adder tree
//   of latency TREE_LAT, tags each launched vector through the tree latency
//   and buffers returned sums in a result FIFO. Launch credits guarantee a
//   FIFO slot for every vector in flight, so the tree never stalls.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     bus          adder_tree_feeder_if.slave (operand in, result out)
//     tree_in      NUM*LEN packed operands to the tree
//     tree_sum     SUM_W sum returned by the tree
//   Macro: ADDER_FEEDER_LAST_EN enables s_last (short vectors, zero-padded).
// -----------------------------------------------------------------------------
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int NUM        = adder_tree_pkg::NUM,
  parameter int LEN        = adder_tree_pkg::LEN,
  parameter int TREE_LAT   = adder_tree_pkg::TREE_LAT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adder_tree_feeder_if.slave        bus,
  output logic [NUM*LEN-1:0]        tree_in,
  input  logic [LEN+TREE_LAT-1:0]   tree_sum
);

  localparam int SUM_W  = LEN + TREE_LAT;
  localparam int CNT_W  = clog2(NUM);
  localparam int CRED_W = clog2(FIFO_DEPTH + 1);

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [NUM*LEN-1:0]   fill_q, fill_w;
  logic [CNT_W-1:0]     cnt_q;
  logic [CRED_W-1:0]    credits_q;
  logic [TREE_LAT-1:0]  vpipe_q;
  logic                 hs, last, complete, launch, pop, has_credit;

`ifdef ADDER_FEEDER_LAST_EN
  assign last = bus.s_last;
`else
  assign last = 1'b0;
`endif

  assign bus.s_ready = ready_q;
  assign hs          = bus.s_valid && ready_q;
  assign complete    = hs && (cnt_q == CNT_W'(NUM - 1) || last);
  assign pop         = bus.m_valid && bus.m_ready;
  assign has_credit  = (credits_q < CRED_W'(FIFO_DEPTH));

  // Fill vector including the operand accepted this cycle, so a completing
  // handshake launches with its own operand already in place.
  always_comb begin
    fill_w = fill_q;
    if (hs) fill_w[cnt_q*LEN +: LEN] = bus.s_data;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (complete) begin
          if (has_credit) launch  = 1'b1;
          else            state_d = HOLD;
        end
      end
      HOLD: begin
        // A pop this cycle frees the credit for the launch at the same edge.
        if (has_credit || pop) begin
          launch  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      ready_q   <= 1'b0;
      fill_q    <= '0;
      cnt_q     <= '0;
      tree_in   <= '0;
      credits_q <= '0;
      vpipe_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == FILL);
      vpipe_q <= {vpipe_q[TREE_LAT-2:0], launch};

      if (launch) begin
        tree_in <= fill_w;
        fill_q  <= '0;
        cnt_q   <= '0;
      end else if (hs) begin
        fill_q <= fill_w;
        cnt_q  <= complete ? '0 : cnt_q + 1'b1;
      end

      unique case ({launch, pop})
        2'b10:   credits_q <= credits_q + 1'b1;
        2'b01:   credits_q <= credits_q - 1'b1;
        default: credits_q <= credits_q;
      endcase
    end
  end

  sum_fifo #(
    .SUM_W      (SUM_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_sum_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vpipe_q[TREE_LAT-1]),
    .push_data (tree_sum),
    .ready     (bus.m_ready),
    .valid     (bus.m_valid),
    .data      (bus.m_data)
  );

endmodule

// File: tb/tb_adder_tree_feeder.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_feeder
//   Directed bench for adder_tree_feeder with a behavioural adder tree of
//   latency TREE_LAT (tree_in register plus TREE_LAT-1 pipeline stages).
//   Built with FIFO_DEPTH=2 so the credit/HOLD path is reachable quickly.
//   The short-vector test is compiled only with ADDER_FEEDER_LAST_EN.
// -----------------------------------------------------------------------------
module tb_adder_tree_feeder;
  import adder_tree_pkg::*;

  localparam int N  = 18;
  localparam int L  = 16;
  localparam int TL = 5;
  localparam int D  = 2;
  localparam int SW = L + TL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_tree_feeder_if #(.LEN(L), .SUM_W(SW)) bus ();
  logic [N*L-1:0] tree_in;
  logic [SW-1:0]  tree_sum;

  adder_tree_feeder #(
    .NUM        (N),
    .LEN        (L),
    .TREE_LAT   (TL),
    .FIFO_DEPTH (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .tree_in  (tree_in),
    .tree_sum (tree_sum)
  );

  // Behavioural tree: combinational sum, then TL-1 register stages.
  logic [SW-1:0] tsum_c;
  logic [SW-1:0] tpipe [TL-1];
  always_comb begin
    tsum_c = '0;
    for (int i = 0; i < N; i++) tsum_c = tsum_c + SW'($signed(tree_in[i*L +: L]));
  end
  always @(posedge clk) begin
    tpipe[0] <= tsum_c;
    for (int i = 1; i < TL - 1; i++) tpipe[i] <= tpipe[i-1];
  end
  assign tree_sum = tpipe[TL-2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [SW-1:0] got [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One operand; returns #1 after the accepting edge. Bounded wait on s_ready.
  task automatic send(input logic [L-1:0] v);
    int waited = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    while (bus.s_ready !== 1'b1 && waited < 200) begin tick(1); waited++; end
    if (bus.s_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, waited);
    end else begin
      tick(1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [L-1:0] v);
    for (int i = 0; i < N; i++) send(v);
  endtask

  task automatic test_reset;
    tick(2);
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.m_data !== '0) begin bad++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
    total++; if (tree_in !== '0) begin bad++; $display("FAIL reset_tree_in: got %h want 0", tree_in); end
    rst_n = 1'b1;
    tick(1);
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_ones;
    logic [N*L-1:0] ones_vec;
    for (int i = 0; i < N; i++) ones_vec[i*L +: L] = 16'd1;
    bus.m_ready = 1'b1;
    got.delete();
    send_vec(16'd1);
    total++; if (tree_in !== ones_vec) begin bad++; $display("FAIL ones_tree_in: got %h want %h", tree_in, ones_vec); end
    for (int k = 1; k <= TL; k++) begin
      tick(1);
      total++;
      if (bus.m_valid !== (k == TL)) begin
        bad++; $display("FAIL ones_latency k=%0d: m_valid=%b want %b", k, bus.m_valid, (k == TL));
      end
    end
    total++; if (bus.m_data !== 21'd18) begin bad++; $display("FAIL ones_m_data: got %0d want 18", bus.m_data); end
    tick(3);
    total++;
    if (got.size() != 1 || got[0] !== 21'd18) begin
      bad++; $display("FAIL ones_result: count=%0d first=%0d want 1 x 18", got.size(), got[0]);
    end
  endtask

  task automatic test_sums;
    logic [L-1:0]  ops  [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [SW-1:0] sums [4] = '{21'h1FFFEE, 21'd589806, 21'h170000, 21'd0};
    bus.m_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      got.delete();
      send_vec(ops[t]);
      tick(TL + 4);
      total++;
      if (got.size() != 1 || got[0] !== sums[t]) begin
        bad++; $display("FAIL sum_%h: count=%0d got %h want %h", ops[t], got.size(), got[0], sums[t]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    bus.m_ready = 1'b1;
    got.delete();
    c0 = cyc;
    send_vec(16'd1);
    send_vec(16'd2);
    total++; if (cyc - c0 != 2 * N) begin bad++; $display("FAIL b2b_cycles: got %0d want %0d", cyc - c0, 2 * N); end
    tick(TL + 4);
    total++;
    if (got.size() != 2 || got[0] !== 21'd18 || got[1] !== 21'd36) begin
      bad++; $display("FAIL b2b_results: count=%0d got %0d,%0d want 18,36", got.size(), got[0], got[1]);
    end
  endtask

  task automatic test_hold;
    int ready_seen = 0;
    bus.m_ready = 1'b0;
    got.delete();
    send_vec(16'd1);
    send_vec(16'd1);
    send_vec(16'd1);
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL hold_enter: s_ready=%b want 0", bus.s_ready); end
    for (int i = 0; i < 10; i++) begin tick(1); if (bus.s_ready !== 1'b0) ready_seen++; end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL hold_stays: s_ready high %0d cycles want 0", ready_seen); end
    total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 21'd18) begin
      bad++; $display("FAIL hold_head: m_valid=%b m_data=%0d want 1,18", bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    tick(1);
    bus.m_ready = 1'b0;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL hold_exit: s_ready=%b want 1", bus.s_ready); end
    total++; if (got.size() != 1 || got[0] !== 21'd18) begin
      bad++; $display("FAIL hold_first_pop: count=%0d got %0d want 1 x 18", got.size(), got[0]);
    end
    // Drain from here: the second result leaves at once, the third must
    // appear exactly TL edges after the launching edge.
    bus.m_ready = 1'b1;
    for (int k = 1; k <= TL; k++) begin
      tick(1);
      total++;
      if (bus.m_valid !== (k == TL)) begin
        bad++; $display("FAIL hold_launch_timing k=%0d: m_valid=%b want %b", k, bus.m_valid, (k == TL));
      end
    end
    tick(3);
    total++;
    if (got.size() != 3 || got[0] !== 21'd18 || got[1] !== 21'd18 || got[2] !== 21'd18) begin
      bad++; $display("FAIL hold_results: count=%0d want 3 x 18", got.size());
    end
  endtask

  task automatic test_reset_mid;
    bus.m_ready = 1'b1;
    got.delete();
    send_vec(16'd5);
    for (int i = 0; i < 3; i++) send(16'd3);
    rst_n = 1'b0;
    tick(1);
    total++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_during: m_valid=%b s_ready=%b want 0,0", bus.m_valid, bus.s_ready);
    end
    tick(1);
    rst_n = 1'b1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL midrst_during2: m_valid=%b want 0", bus.m_valid); end
    tick(1);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL midrst_after: m_valid=%b want 0", bus.m_valid); end
    send_vec(16'd1);
    tick(TL + 4);
    total++;
    if (got.size() != 1 || got[0] !== 21'd18) begin
      bad++; $display("FAIL midrst_result: count=%0d first=%0d want 1 x 18", got.size(), got[0]);
    end
  endtask

`ifdef ADDER_FEEDER_LAST_EN
  task automatic test_last;
    bus.m_ready = 1'b1;
    got.delete();
    send(16'd5);
    send(16'd6);
    bus.s_last = 1'b1;
    send(16'd7);
    bus.s_last = 1'b0;
    tick(TL + 4);
    total++; if (got.size() != 1 || got[0] !== 21'd18) begin
      bad++; $display("FAIL last_short: count=%0d got %0d want 1 x 18", got.size(), got[0]);
    end
    send_vec(16'd2);
    tick(TL + 4);
    total++; if (got.size() != 2 || got[1] !== 21'd36) begin
      bad++; $display("FAIL last_next_full: count=%0d got %0d want 36", got.size(), got[1]);
    end
  endtask
`endif

  task automatic test_random;
    logic [SW-1:0] exp_q [$];
    bit            done = 1'b0;
    int            waited = 0;
    int            errs = 0;
    got.delete();
    fork
      begin
        for (int v = 0; v < 1000; v++) begin
          int s = 0;
          for (int i = 0; i < N; i++) begin
            logic [L-1:0] op;
            op = L'($urandom);
            if ($urandom_range(0, 3) == 0) tick(1);
            s += $signed(op);
            send(op);
          end
          exp_q.push_back(SW'(s));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin tick(1); bus.m_ready = 1'($urandom_range(0, 1)); end
      end
    join
    bus.m_ready = 1'b1;
    while (got.size() < exp_q.size() && waited < 100) begin tick(1); waited++; end
    tick(2);
    total++; if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: pops=%0d launches=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      if (got[i] !== exp_q[i]) begin
        errs++;
        if (errs <= 5) $display("FAIL rand_sum[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rand_sums: %0d wrong results, want 0", errs); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
`ifdef ADDER_FEEDER_LAST_EN
    bus.s_last  = 1'b0;
`endif
    #1;
    test_reset();
    test_ones();
    test_sums();
    test_back_to_back();
    test_hold();
    test_reset_mid();
`ifdef ADDER_FEEDER_LAST_EN
    test_last();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
